// File: rtl/bcd_display_scheduler_if.sv
// Requester-side handshake bundle for the shared BCD converter scheduler.
// Score and timer each present a level request with a stable value until acked.
interface bcd_display_scheduler_if;
  logic       score_req;
  logic [9:0] score_bin;
  logic       score_ack;
  logic       time_req;
  logic [9:0] time_bin;
  logic       time_ack;

  modport master (
    output score_req, score_bin, time_req, time_bin,
    input  score_ack, time_ack
  );

  modport slave (
    input  score_req, score_bin, time_req, time_bin,
    output score_ack, time_ack
  );
endinterface

// File: rtl/bcd_display_scheduler.sv
// Time-shares one external Bin2BCD converter between score and timer requesters,
// caches each BCD result and scans the selected cache onto a 4-digit 7-seg display.
module bcd_display_scheduler #(
  parameter int unsigned CONV_LAT = 1,
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_display_scheduler_if.slave  sched,
  output logic [9:0]              conv_bin,
  input  logic [15:0]             conv_bcd,
  input  logic                    disp_sel,
  output logic                    busy,
  output logic [3:0]              an,
  output logic [3:0]              digit
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  typedef enum logic {GRANT_SCORE, GRANT_TIME} grant_t;

  state_t      state, state_nxt;
  grant_t      grant, grant_nxt;
  grant_t      last_grant, last_grant_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [9:0]  conv_bin_nxt;
  logic [15:0] score_cache, score_cache_nxt;
  logic [15:0] time_cache, time_cache_nxt;
  logic        score_ack, score_ack_nxt;
  logic        time_ack, time_ack_nxt;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    scan_idx;
  logic [15:0]   shown;
  logic          upper_zero;
  logic          blank;
  logic [3:0]    an_nxt;
  logic [3:0]    digit_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= GRANT_SCORE;
      last_grant  <= GRANT_TIME;
      cnt         <= '0;
      conv_bin    <= '0;
      score_cache <= '0;
      time_cache  <= '0;
      score_ack   <= 1'b0;
      time_ack    <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      cnt         <= cnt_nxt;
      conv_bin    <= conv_bin_nxt;
      score_cache <= score_cache_nxt;
      time_cache  <= time_cache_nxt;
      score_ack   <= score_ack_nxt;
      time_ack    <= time_ack_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    last_grant_nxt  = last_grant;
    cnt_nxt         = cnt;
    conv_bin_nxt    = conv_bin;
    score_cache_nxt = score_cache;
    time_cache_nxt  = time_cache;
    score_ack_nxt   = 1'b0;
    time_ack_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (sched.score_req || sched.time_req) begin
          // Contention goes to whoever was not served last; score wins after reset.
          if (sched.score_req && (!sched.time_req || last_grant == GRANT_TIME)) begin
            grant_nxt    = GRANT_SCORE;
            conv_bin_nxt = sched.score_bin;
          end else begin
            grant_nxt    = GRANT_TIME;
            conv_bin_nxt = sched.time_bin;
          end
          cnt_nxt   = 4'(CONV_LAT);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          if (grant == GRANT_SCORE) begin
            score_cache_nxt = conv_bcd;
            score_ack_nxt   = 1'b1;
          end else begin
            time_cache_nxt  = conv_bcd;
            time_ack_nxt    = 1'b1;
          end
          last_grant_nxt = grant;
          state_nxt      = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign sched.score_ack = score_ack;
  assign sched.time_ack  = time_ack;

  always_comb begin
    shown      = disp_sel ? time_cache : score_cache;
    upper_zero = 1'b0;
    case (scan_idx)
      2'd1:    upper_zero = (shown[15:4] == 12'd0);
      2'd2:    upper_zero = (shown[15:8] == 8'd0);
      2'd3:    upper_zero = (shown[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
    // Ones slot never reaches the blank path, so a zero value still shows "0".
    blank     = BLANK_LZ && upper_zero;
    an_nxt    = blank ? '1 : ~(4'b0001 << scan_idx);
    digit_nxt = blank ? '0 : shown[{scan_idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= '1;
      digit    <= '0;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an    <= an_nxt;
      digit <= digit_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed bench: instance A (CONV_LAT=1, blanking) and instance B (CONV_LAT=3, no blanking)
// each fed by a behavioural Bin2BCD converter.
module tb_bcd_display_scheduler;

  logic clk;
  logic rst_n;

  bcd_display_scheduler_if ifa ();
  bcd_display_scheduler_if ifb ();

  logic [9:0]  conv_bin_a, conv_bin_b;
  logic [15:0] conv_bcd_a, conv_bcd_b;
  logic        disp_sel_a, disp_sel_b;
  logic        busy_a, busy_b;
  logic [3:0]  an_a, an_b;
  logic [3:0]  digit_a, digit_b;

  int unsigned passed;
  int unsigned total;

  function automatic logic [15:0] bin2bcd(input logic [9:0] v);
    int unsigned x;
    x = v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  assign conv_bcd_a = bin2bcd(conv_bin_a);
  assign conv_bcd_b = bin2bcd(conv_bin_b);

  bcd_display_scheduler #(.CONV_LAT(1), .SCAN_DIV(4), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .sched(ifa), .conv_bin(conv_bin_a), .conv_bcd(conv_bcd_a),
    .disp_sel(disp_sel_a), .busy(busy_a), .an(an_a), .digit(digit_a)
  );

  bcd_display_scheduler #(.CONV_LAT(3), .SCAN_DIV(4), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .sched(ifb), .conv_bin(conv_bin_b), .conv_bcd(conv_bcd_b),
    .disp_sel(disp_sel_b), .busy(busy_b), .an(an_b), .digit(digit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.score_req = 1'b0; ifa.score_bin = '0; ifa.time_req = 1'b0; ifa.time_bin = '0;
    ifb.score_req = 1'b0; ifb.score_bin = '0; ifb.time_req = 1'b0; ifb.time_bin = '0;
    disp_sel_a = 1'b0; disp_sel_b = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++; if (an_a !== 4'b1111) $display("FAIL rst_an: got %b want 1111", an_a); else passed++;
    total++; if (digit_a !== 4'd0) $display("FAIL rst_digit: got %0d want 0", digit_a); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else passed++;
    total++; if (conv_bin_a !== 10'd0) $display("FAIL rst_conv_bin: got %0d want 0", conv_bin_a); else passed++;
    total++; if ({ifa.score_ack, ifa.time_ack} !== 2'b00) $display("FAIL rst_acks: got %b want 00", {ifa.score_ack, ifa.time_ack}); else passed++;
    rst_n = 1'b1;
    ifb.score_req = 1'b1; ifb.score_bin = 10'd500;
    tick();
    total++; if (busy_b !== 1'b1) $display("FAIL rst_grant_busy: got %b want 1", busy_b); else passed++;
    total++; if (conv_bin_b !== 10'd500) $display("FAIL rst_grant_bin: got %0d want 500", conv_bin_b); else passed++;
    tick();
    rst_n = 1'b0;
    ifb.score_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ifb.score_ack !== 1'b0) $display("FAIL rst_mid_ack: got %b want 0", ifb.score_ack); else passed++;
      total++; if (busy_b !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy_b); else passed++;
      total++; if (an_b !== 4'b1111) $display("FAIL rst_mid_an: got %b want 1111", an_b); else passed++;
    end
    rst_n = 1'b1;
    tick();
    total++; if (u_b.score_cache !== 16'h0000) $display("FAIL rst_cache: got %h want 0000", u_b.score_cache); else passed++;
    total++; if (an_a !== 4'b1110) $display("FAIL rst_first_an: got %b want 1110", an_a); else passed++;
    total++; if (digit_a !== 4'd0) $display("FAIL rst_first_digit: got %0d want 0", digit_a); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ifb.score_ack !== 1'b0) $display("FAIL rst_no_ack: got %b want 0", ifb.score_ack); else passed++;
    end
  endtask

  task automatic test_single();
    ifa.score_req = 1'b1; ifa.score_bin = 10'd347;
    tick();
    total++; if (conv_bin_a !== 10'd347) $display("FAIL single_conv_bin: got %0d want 347", conv_bin_a); else passed++;
    total++; if (ifa.score_ack !== 1'b0) $display("FAIL single_early_ack: got %b want 0", ifa.score_ack); else passed++;
    tick();
    total++; if (ifa.score_ack !== 1'b1) $display("FAIL single_ack: got %b want 1", ifa.score_ack); else passed++;
    total++; if (ifa.time_ack !== 1'b0) $display("FAIL single_time_ack: got %b want 0", ifa.time_ack); else passed++;
    total++; if (u_a.score_cache !== 16'h0347) $display("FAIL single_cache: got %h want 0347", u_a.score_cache); else passed++;
    ifa.score_req = 1'b0;
    tick();
    total++; if (ifa.score_ack !== 1'b0) $display("FAIL single_ack_width: got %b want 0", ifa.score_ack); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL single_idle: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_contention();
    logic exp_score;
    rst_n = 1'b0;
    tick();
    ifa.score_req = 1'b1; ifa.score_bin = 10'd5;
    ifa.time_req = 1'b1;  ifa.time_bin = 10'd1023;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_score = (k != 1);
      tick();
      total++;
      if (conv_bin_a !== (exp_score ? 10'd5 : 10'd1023))
        $display("FAIL rr_grant%0d: got %0d want %0d", k, conv_bin_a, exp_score ? 5 : 1023);
      else passed++;
      tick();
      total++;
      if ({ifa.score_ack, ifa.time_ack} !== {exp_score, !exp_score})
        $display("FAIL rr_ack%0d: got %b want %b", k, {ifa.score_ack, ifa.time_ack}, {exp_score, !exp_score});
      else passed++;
      if (k == 2) begin
        ifa.score_req = 1'b0; ifa.time_req = 1'b0;
      end
      tick();
      total++;
      if ({ifa.score_ack, ifa.time_ack} !== 2'b00)
        $display("FAIL rr_ack_clear%0d: got %b want 00", k, {ifa.score_ack, ifa.time_ack});
      else passed++;
    end
    total++; if (u_a.score_cache !== 16'h0005) $display("FAIL rr_score_cache: got %h want 0005", u_a.score_cache); else passed++;
    total++; if (u_a.time_cache !== 16'h1023) $display("FAIL rr_time_cache: got %h want 1023", u_a.time_cache); else passed++;
  endtask

  task automatic test_display();
    logic [15:0] ean, edig;
    logic [3:0]  prev, e0;
    logic        found;
    ifa.score_req = 1'b1; ifa.score_bin = 10'd42;
    tick(); tick();
    ifa.score_req = 1'b0;
    tick();
    for (int sc = 0; sc < 2; sc++) begin
      disp_sel_a = (sc == 1);
      ean  = (sc == 0) ? 16'hFFDE : 16'h7BDE;
      edig = (sc == 0) ? 16'h0042 : 16'h1023;
      e0   = ean[3:0];
      tick();
      found = 1'b0;
      prev  = an_a;
      for (int n = 0; n < 64 && !found; n++) begin
        tick();
        if (prev !== e0 && an_a === e0) found = 1'b1;
        else prev = an_a;
      end
      total++;
      if (!found) $display("FAIL disp%0d_sync: got no slot0 start, want an %b within 64 cycles", sc, e0);
      else passed++;
      for (int i = 0; i < 16; i++) begin
        if (i > 0) tick();
        total++;
        if (an_a !== ean[4*((i/4)%4) +: 4])
          $display("FAIL disp%0d_an c%0d: got %b want %b", sc, i, an_a, ean[4*((i/4)%4) +: 4]);
        else passed++;
        total++;
        if (digit_a !== edig[4*((i/4)%4) +: 4])
          $display("FAIL disp%0d_digit c%0d: got %0d want %0d", sc, i, digit_a, edig[4*((i/4)%4) +: 4]);
        else passed++;
      end
    end
  endtask

  task automatic test_no_blank();
    logic [15:0] ean;
    logic [3:0]  prev;
    logic        found;
    ean = 16'h7BDE;
    disp_sel_b = 1'b0;
    tick();
    found = 1'b0;
    prev  = an_b;
    for (int n = 0; n < 64 && !found; n++) begin
      tick();
      if (prev !== 4'b1110 && an_b === 4'b1110) found = 1'b1;
      else prev = an_b;
    end
    total++;
    if (!found) $display("FAIL noblank_sync: got no slot0 start, want an 1110 within 64 cycles");
    else passed++;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      total++;
      if (an_b !== ean[4*((i/4)%4) +: 4])
        $display("FAIL noblank_an c%0d: got %b want %b", i, an_b, ean[4*((i/4)%4) +: 4]);
      else passed++;
      total++;
      if (digit_b !== 4'd0) $display("FAIL noblank_digit c%0d: got %0d want 0", i, digit_b);
      else passed++;
    end
  endtask

  task automatic test_latency();
    int  n;
    logic found;
    ifb.score_req = 1'b1; ifb.score_bin = 10'd777;
    tick();
    total++; if (conv_bin_b !== 10'd777) $display("FAIL lat_grant: got %0d want 777", conv_bin_b); else passed++;
    n = 0; found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      tick();
      if (ifb.score_ack === 1'b1) begin found = 1'b1; n = k; end
    end
    total++; if (n != 3) $display("FAIL lat_score: got %0d edges want 3", n); else passed++;
    total++; if (u_b.score_cache !== 16'h0777) $display("FAIL lat_score_cache: got %h want 0777", u_b.score_cache); else passed++;
    ifb.time_req = 1'b1; ifb.time_bin = 10'd999;
    tick();
    total++; if (busy_b !== 1'b0) $display("FAIL lat_gap_busy: got %b want 0", busy_b); else passed++;
    total++; if (ifb.score_ack !== 1'b0) $display("FAIL lat_ack_width: got %b want 0", ifb.score_ack); else passed++;
    tick();
    total++; if (busy_b !== 1'b1) $display("FAIL lat_regrant_busy: got %b want 1", busy_b); else passed++;
    total++; if (conv_bin_b !== 10'd999) $display("FAIL lat_regrant_bin: got %0d want 999", conv_bin_b); else passed++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (ifb.time_ack !== (k == 3)) $display("FAIL lat_time_ack e%0d: got %b want %b", k, ifb.time_ack, k == 3);
      else passed++;
      total++;
      if (ifb.score_ack !== 1'b0) $display("FAIL lat_score_quiet e%0d: got %b want 0", k, ifb.score_ack);
      else passed++;
    end
    total++; if (u_b.time_cache !== 16'h0999) $display("FAIL lat_time_cache: got %h want 0999", u_b.time_cache); else passed++;
    ifb.score_req = 1'b0; ifb.time_req = 1'b0;
    tick();
    total++; if (ifb.time_ack !== 1'b0) $display("FAIL lat_time_width: got %b want 0", ifb.time_ack); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_contention();
    test_display();
    test_no_blank();
    test_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
